// File: rtl/dct_da_ctrl.sv
// rtl/dct_da_ctrl.sv - DA DCT coefficient lane sequencer/accumulator (optional DA_ROUND_EN rounding)
// Walks 4 samples LSB-first, folds the ROM MSB address bit by antisymmetry, shift-accumulates.
module dct_da_ctrl #(
    parameter int DW  = 16,
    parameter int RW  = 16,
    parameter int RSH = 14,
    parameter int OW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        x0,
    input  logic [DW-1:0]        x1,
    input  logic [DW-1:0]        x2,
    input  logic [DW-1:0]        x3,
    output logic                 rom_cs,
    output logic [2:0]           rom_addr,
    input  logic signed [RW-1:0] rom_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] z_out,
    output logic                 busy
);
    localparam int AW = RW + DW + 1;
    localparam int JW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {WARM, IDLE, RUN, HOLD} state_t;

    state_t                 state, state_next;
    logic [JW-1:0]          j;
    logic [DW-1:0]          x0_r, x1_r, x2_r, x3_r;
    logic signed [AW-1:0]   acc;
    logic                   last, neg, neg_eff;
    logic [2:0]             addr_raw;
    logic signed [AW-1:0]   t_ext, t_term, acc_next, acc_rnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WARM;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        rom_cs     = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            WARM: state_next = IDLE;
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                rom_cs = 1'b1;
                busy   = 1'b1;
                if (last) state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = WARM;
        endcase
    end

    // Only half the table is stored: b0=1 reads the complement address and negates.
    always_comb begin
        last     = (j == JW'(DW - 1));
        neg      = x0_r[j];
        addr_raw = {x1_r[j], x2_r[j], x3_r[j]};
        rom_addr = rom_cs ? (addr_raw ^ {3{neg}}) : 3'd0;
        t_ext    = {{(AW-RW){rom_data[RW-1]}}, rom_data};
        neg_eff  = neg ^ last;
        t_term   = neg_eff ? -t_ext : t_ext;
        acc_next = acc + (t_term <<< j);
`ifdef DA_ROUND_EN
        acc_rnd  = acc_next + (AW'(1) <<< (RSH - 1));
`else
        acc_rnd  = acc_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j     <= '0;
            x0_r  <= '0;
            x1_r  <= '0;
            x2_r  <= '0;
            x3_r  <= '0;
            acc   <= '0;
            z_out <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                x0_r <= x0;
                x1_r <= x1;
                x2_r <= x2;
                x3_r <= x3;
                acc  <= '0;
                j    <= '0;
            end else if (state == RUN) begin
                acc <= acc_next;
                j   <= j + JW'(1);
                if (last) z_out <= OW'(acc_rnd >>> RSH);
            end
        end
    end
endmodule

// File: tb/tb_dct_da_ctrl.sv
// tb/tb_dct_da_ctrl.sv - self-checking bench for dct_da_ctrl (honours DA_ROUND_EN)
module tb_dct_da_ctrl;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [15:0]        x0 = '0, x1 = '0, x2 = '0, x3 = '0;
    logic               rom_cs;
    logic [2:0]         rom_addr;
    logic signed [15:0] rom_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] z_out;
    logic               busy;

    logic signed [15:0] rom_tbl [8];
    logic               zero_win;
    int                 tests = 0;
    int                 fails = 0;

    always #5 clk = ~clk;

    dct_da_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .z_out(z_out), .busy(busy)
    );

    always @(posedge clk or negedge rst_n)
        if (!rst_n) zero_win <= 1'b1;
        else        zero_win <= 1'b0;
    assign rom_data = zero_win ? 16'sd0 : rom_tbl[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full-table DA sum: T(0,a)=ROM[a], T(1,a)=-ROM[~a], MSB weighted negatively.
    function automatic logic [15:0] model_z(input logic [15:0] a, b, c, d);
        longint acc = 0;
        longint t, w;
        int idx;
        for (int k = 0; k < 16; k++) begin
            idx = {b[k], c[k], d[k]};
            t = a[k] ? -longint'(rom_tbl[7 - idx]) : longint'(rom_tbl[idx]);
            w = (k == 15) ? -(longint'(1) << 15) : (longint'(1) << k);
            acc += t * w;
        end
`ifdef DA_ROUND_EN
        acc += longint'(1) << 13;
`endif
        acc = acc >>> 14;
        return acc[15:0];
    endfunction

    function automatic logic [2:0] model_addr(input logic [15:0] a, b, c, d, input int k);
        logic [2:0] r;
        r = {b[k], c[k], d[k]};
        return a[k] ? ~r : r;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    // Accept a set, check every RUN cycle, then hold for hold_cycles before the handshake.
    task automatic run_txn(input logic [15:0] a, b, c, d, input int hold_cycles);
        logic [15:0] exp_z;
        logic [15:0] zs;
        exp_z = model_z(a, b, c, d);
        wait_ready();
        x0 = a; x1 = b; x2 = c; x3 = d;
        in_valid = 1'b1;
        @(negedge clk);
        x0 = $urandom; x1 = $urandom; x2 = $urandom; x3 = $urandom;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("run%0d_cs", k), {31'd0, rom_cs}, 32'd1);
            check($sformatf("run%0d_addr", k), {29'd0, rom_addr}, {29'd0, model_addr(a, b, c, d, k)});
            check($sformatf("run%0d_rdy", k), {31'd0, in_ready}, 32'd0);
            check($sformatf("run%0d_ov", k), {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("hold_ov", {31'd0, out_valid}, 32'd1);
        check("z_out", {16'd0, z_out}, {16'd0, exp_z});
        zs = z_out;
        for (int k = 0; k < hold_cycles; k++) begin
            @(negedge clk);
            check("hold_ov_stable", {31'd0, out_valid}, 32'd1);
            check("hold_z_stable", {16'd0, z_out}, {16'd0, zs});
            check("hold_rdy", {31'd0, in_ready}, 32'd0);
            check("hold_busy", {31'd0, busy}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_ov", {31'd0, out_valid}, 32'd0);
        check("post_rdy", {31'd0, in_ready}, 32'd1);
        check("post_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rom_tbl[i] = 16'sd0;
        rom_tbl[1] = 16'sh2D41; rom_tbl[2] = 16'shD2BE; rom_tbl[4] = 16'shD2BE;
        rom_tbl[6] = 16'shA57D; rom_tbl[7] = 16'shD2BE;

        in_valid = 1'b1; x3 = 16'h4000;
        #1;
        check("rst_rdy", {31'd0, in_ready}, 32'd0);
        check("rst_cs", {31'd0, rom_cs}, 32'd0);
        check("rst_ov", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr", {29'd0, rom_addr}, 32'd0);
        check("rst_z", {16'd0, z_out}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        check("warm_rdy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("idle_rdy", {31'd0, in_ready}, 32'd1);
        run_txn(16'h0000, 16'h0000, 16'h0000, 16'h4000, 0);
        check("dir_x3_4000", {16'd0, z_out}, 32'd11585);

        run_txn(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0);
        check("dir_x0_m1", {16'd0, z_out}, 32'h0000FFFF);

        run_txn(16'h0000, 16'h0000, 16'h0000, 16'h2000, 5);
`ifdef DA_ROUND_EN
        check("dir_x3_2000", {16'd0, z_out}, 32'd5793);
`else
        check("dir_x3_2000", {16'd0, z_out}, 32'd5792);
`endif

        // Reset at j=7 of a RUN: outputs clear at once, then WARM repeats.
        wait_ready();
        x0 = 16'h1234; x1 = 16'h5678; x2 = 16'h9ABC; x3 = 16'hDEF0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) @(negedge clk);
        check("mid_cs_before", {31'd0, rom_cs}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs", {31'd0, rom_cs}, 32'd0);
        check("mid_rst_ov", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_z", {16'd0, z_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_warm_rdy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("mid_idle_rdy", {31'd0, in_ready}, 32'd1);
        run_txn(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1);

        // Random ROM contents (including 0x8000) and random samples.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 8; i++) rom_tbl[i] = 16'($urandom);
            rom_tbl[$urandom_range(7, 0)] = 16'sh8000;
            run_txn(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(3, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dct_da_ctrl.md
Name: dct_da_ctrl

Overview:
- Sequencer and accumulator for one distributed-arithmetic (DA) DCT coefficient lane.
- Accepts 4 two's-complement samples, walks their bits LSB-first and drives the 3-bit coefficient ROM (cs/addr). The ROM is combinational from addr, with a 1-cycle post-reset zero window.
- Folds the 4th address bit by table antisymmetry, shift-accumulates the ROM words and presents one scaled coefficient per transaction on a valid/ready output.

Parameters:
- DW, 16, sample width (two's complement); number of RUN cycles per transaction.
- RW, 16, ROM word width, signed Q1.14.
- RSH, 14, right shift applied to the accumulator to form z_out.
- OW, 16, output width.
- (localparam) AW = RW+DW+1, accumulator width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample set valid.
- in_ready  out  1  controller can accept a sample set.
- x0, x1, x2, x3  in  DW each  samples, signed.
- rom_cs  out  1  ROM chip select.
- rom_addr  out  3  ROM address.
- rom_data  in  RW  ROM word, signed, combinational from rom_addr.
- out_valid  out  1  z_out valid.
- out_ready  in  1  downstream accepts z_out.
- z_out  out  OW  scaled coefficient, signed.
- busy  out  1  high in RUN or HOLD.

Behaviour:
- Reset (async): state=WARM; in_ready, rom_cs, out_valid and busy = 0; rom_addr, z_out, accumulator, bit counter and sample registers = 0.
- FSM states: WARM, IDLE, RUN, HOLD.
- WARM: exactly 1 cycle after rst_n release, covering the ROM's zero window; then IDLE.
- IDLE: in_ready=1. On in_valid&in_ready: latch x0..x3, acc=0, j=0, go RUN.
- RUN: DW cycles, j=0..DW-1. in_ready=0, rom_cs=1.
  - Let b0..b3 = bit j of x0..x3.
  - b0=0: rom_addr={b1,b2,b3}, neg=0. b0=1: rom_addr=~{b1,b2,b3}, neg=1.
  - rom_addr and neg are combinational from the registered j and sample bits; rom_data is consumed in the same cycle.
  - t = sign-extend(rom_data) to AW, negated if neg. Negate t again if j=DW-1 (sign-bit weight).
  - acc <= acc + (t << j).
  - After j=DW-1: go HOLD, out_valid<=1, z_out<=acc[RSH+OW-1:RSH] (arithmetic, wraps).
- Full-table contract: T(0,a)=ROM[a] and T(1,a)=-ROM[~a]. Hence z = sum_j w_j*T(bits_j) >> RSH, with w_j=2^j for j<DW-1 and w_{DW-1}=-2^(DW-1).
- HOLD: out_valid=1 and z_out stable until out_ready. On out_valid&out_ready: out_valid<=0, go IDLE.
  - in_ready rises the cycle after the handshake. No overlap of transactions.
- Latency: input accepted in cycle k -> rom_cs high k+1..k+DW -> out_valid from k+DW+1.
- Outside RUN: rom_cs=0, rom_addr=0.
- in_valid during RUN or HOLD is ignored; it is not latched.
- rom_data 0x8000 is handled exactly (extend before negate).
- Reset mid-operation: all outputs clear immediately, the transaction is dropped, and the WARM cycle is repeated.

Optional Feature:
- DA_ROUND_EN defined: z_out = (acc + 2^(RSH-1)) >> RSH, round-half-up, then truncated to OW (wraps).
- Undefined: plain arithmetic truncation, acc >> RSH.
- No other behaviour differs.

Test Plan:
- Reset release, in_valid held high -> in_ready=0 in the first cycle after release, 1 in the second. The first set is accepted in the second cycle.
- ROM model: addr1=0x2D41, addr2=0xD2BE, addr4=0xD2BE, addr6=0xA57D, addr7=0xD2BE, others 0.
  - Stimulus: x0=x1=x2=0, x3=0x4000.
  - Required: rom_addr=1 only at j=14, otherwise 0. z_out=11585 with or without the macro.
- x0=0xFFFF (-1), x1..x3=0 -> rom_addr=7 every RUN cycle with neg=1 -> acc=-11586, z_out=-1 (0xFFFF) with or without the macro.
- x3=0x2000, others 0 -> z_out=5792 without DA_ROUND_EN; 5793 with it.
- Accept at cycle k (DW=16) -> rom_cs high k+1..k+16, out_valid at k+17.
  - Then hold out_ready=0 for 5 cycles: out_valid and z_out stable, in_ready=0.
  - Then out_ready=1: in_ready=1 one cycle later.
- rst_n asserted at j=7 of RUN -> rom_cs, out_valid, busy and z_out=0 immediately. After release: WARM cycle, then a fresh transaction gives correct results.
